// File: rtl/mac_tile_sequencer.sv
// mac_tile_sequencer
// Runs one dot-product job: issues paired weight/data buffer reads, one per tile,
// follows them through the buffer read and the multiplier pipeline, strobes the
// accumulator, then offers the result on a valid/ready handshake and pulses done.
// Every output is a flop. Each output flop is loaded from the next-state decode, so
// the outputs always match the state currently held in the state register.

module mac_tile_sequencer #(
  parameter int N   = 144,  // multiplier lanes; no datapath in this block
  parameter int LAT = 3,    // multiplier pipeline latency, >= 1
  parameter int AW  = 10,   // buffer address width
  parameter int CW  = 10    // tile-count width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_tiles,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] d_base,
  output logic          busy,
  output logic          w_rd_en,
  output logic [AW-1:0] w_rd_addr,
  output logic          d_rd_en,
  output logic [AW-1:0] d_rd_addr,
  output logic          acc_en,
  output logic          acc_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done
);

  generate
    if (LAT < 1 || N < 1) begin : g_param_check
      $error("mac_tile_sequencer: LAT and N must both be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_RESULT = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t          state_r, state_nxt;
  logic [CW-1:0]   tiles_r, tiles_nxt;
  logic [CW-1:0]   cnt_r, cnt_nxt;      // tiles issued so far, including this cycle
  logic [AW-1:0]   w_addr_nxt, d_addr_nxt;
  logic            rd_en_nxt;
  logic            first_r, first_nxt;  // marks the read of tile 0
  logic [LAT-1:0]  vpipe_r;             // read strobe travelling through read + multiply
  logic [LAT-1:0]  fpipe_r;             // first-tile flag travelling alongside it

  // Next-state and next-output decode; addresses wrap silently at 2^AW.
  always_comb begin
    state_nxt  = state_r;
    tiles_nxt  = tiles_r;
    cnt_nxt    = cnt_r;
    w_addr_nxt = w_rd_addr;
    d_addr_nxt = d_rd_addr;
    rd_en_nxt  = 1'b0;
    first_nxt  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (num_tiles != {CW{1'b0}}) begin
            state_nxt  = S_ISSUE;
            tiles_nxt  = num_tiles;
            cnt_nxt    = CNT_ONE;
            w_addr_nxt = w_base;
            d_addr_nxt = d_base;
            rd_en_nxt  = 1'b1;
            first_nxt  = 1'b1;
          end else begin
            state_nxt = S_FIN;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cnt_r == tiles_r) begin
          state_nxt = S_DRAIN;
        end else begin
          cnt_nxt    = cnt_r + CNT_ONE;
          w_addr_nxt = w_rd_addr + ADDR_ONE;
          d_addr_nxt = d_rd_addr + ADDR_ONE;
          rd_en_nxt  = 1'b1;
        end
      end
      S_DRAIN: begin
        // The last read has left the pipe once every stage is empty; the final
        // acc_en is in its output flop this cycle, so out_valid follows it.
        if (vpipe_r == {LAT{1'b0}}) begin
          state_nxt = S_RESULT;
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          state_nxt = S_FIN;
        end else begin
          state_nxt = S_RESULT;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, job registers and output flops loaded from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      tiles_r   <= {CW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      first_r   <= 1'b0;
      busy      <= 1'b0;
      w_rd_en   <= 1'b0;
      d_rd_en   <= 1'b0;
      w_rd_addr <= {AW{1'b0}};
      d_rd_addr <= {AW{1'b0}};
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      tiles_r   <= tiles_nxt;
      cnt_r     <= cnt_nxt;
      first_r   <= first_nxt;
      busy      <= (state_nxt != S_IDLE);
      w_rd_en   <= rd_en_nxt;
      d_rd_en   <= rd_en_nxt;
      w_rd_addr <= w_addr_nxt;
      d_rd_addr <= d_addr_nxt;
      out_valid <= (state_nxt == S_RESULT);
      done      <= (state_nxt == S_FIN);
    end
  end

  // Valid pipe: one stage for the buffer read plus LAT multiplier stages,
  // the last stage being the acc_en/acc_clr output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_r <= {LAT{1'b0}};
      fpipe_r <= {LAT{1'b0}};
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
    end else begin
      vpipe_r[0] <= w_rd_en;
      fpipe_r[0] <= w_rd_en & first_r;
      for (int i = 1; i < LAT; i++) begin
        vpipe_r[i] <= vpipe_r[i-1];
        fpipe_r[i] <= fpipe_r[i-1];
      end
      acc_en  <= vpipe_r[LAT-1];
      acc_clr <= vpipe_r[LAT-1] & fpipe_r[LAT-1];
    end
  end

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Bench for mac_tile_sequencer. Expected read addresses and acc_clr flags are
// queued when a job is started; a negedge monitor queues what the DUT actually
// produced, and each test compares the two plus cycle-exact strobe timing.
// Cycle 0 is the cycle in which start is high.

module tb_mac_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] num_tiles;
  logic [9:0] w_base;
  logic [9:0] d_base;
  logic       busy, w_rd_en, d_rd_en, acc_en, acc_clr, out_valid, out_ready, done;
  logic [9:0] w_rd_addr, d_rd_addr;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_w[$], exp_d[$], obs_w[$], obs_d[$];
  logic       exp_clr[$], obs_clr[$];
  int         done_cnt = 0;
  int         en_mis   = 0;

  mac_tile_sequencer #(.N(144), .LAT(3), .AW(10), .CW(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .w_base(w_base), .d_base(d_base), .busy(busy),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .done(done)
  );

  always #5 clk = ~clk;

  // Monitor: record observed reads, accumulator strobes and done pulses.
  always @(negedge clk) begin
    if (w_rd_en === 1'b1) begin
      obs_w.push_back(w_rd_addr);
      obs_d.push_back(d_rd_addr);
    end
    if (acc_en === 1'b1) obs_clr.push_back(acc_clr);
    if (d_rd_en !== w_rd_en) en_mis++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_sb();
    exp_w.delete(); exp_d.delete(); exp_clr.delete();
    obs_w.delete(); obs_d.delete(); obs_clr.delete();
    done_cnt = 0;
    en_mis   = 0;
  endtask

  // Drive start in the next cycle (cycle 0) and queue the expected reads.
  task automatic begin_job(input logic [9:0] wb, input logic [9:0] db, input int k);
    logic [9:0] off;
    @(posedge clk); #1;
    clear_sb();
    start = 1'b1; num_tiles = 10'(k); w_base = wb; d_base = db;
    for (int i = 0; i < k; i++) begin
      off = 10'(i);
      exp_w.push_back(wb + off);
      exp_d.push_back(db + off);
      exp_clr.push_back(i == 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_tiles = 10'd0; w_base = 10'd0; d_base = 10'd0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, w_rd_en, d_rd_en, acc_en, acc_clr, out_valid, done} !== 7'd0 ||
        w_rd_addr !== 10'd0 || d_rd_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got strobes=%b waddr=%h daddr=%h required all 0",
               {busy, w_rd_en, d_rd_en, acc_en, acc_clr, out_valid, done}, w_rd_addr, d_rd_addr);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b required 0", busy);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic e_rd, e_acc, e_clr, e_ov, e_done, e_busy;
    logic [9:0] ew, ed, ow, od;
    logic ec, oc;
    out_ready = 1'b1;
    begin_job(10'h010, 10'h200, 4);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      e_rd = (c >= 1 && c <= 4); e_acc = (c >= 5 && c <= 8); e_clr = (c == 5);
      e_ov = (c == 9); e_done = (c == 10); e_busy = (c >= 1 && c <= 10);
      checks++;
      if ({w_rd_en, acc_en, acc_clr, out_valid, done, busy} !==
          {e_rd, e_acc, e_clr, e_ov, e_done, e_busy}) begin
        errors++;
        $display("FAIL basic_timing cycle %0d got rd/acc/clr/ov/done/busy=%b required %b", c,
                 {w_rd_en, acc_en, acc_clr, out_valid, done, busy},
                 {e_rd, e_acc, e_clr, e_ov, e_done, e_busy});
      end
      @(posedge clk); #1; start = 1'b0;
    end
    checks++;
    if (obs_w.size() != exp_w.size() || obs_clr.size() != exp_clr.size() || en_mis != 0) begin
      errors++;
      $display("FAIL basic_count reads %0d required %0d, acc_en %0d required %0d, d/w enable mismatches %0d",
               obs_w.size(), exp_w.size(), obs_clr.size(), exp_clr.size(), en_mis);
    end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      ew = exp_w.pop_front(); ed = exp_d.pop_front(); ow = obs_w.pop_front(); od = obs_d.pop_front();
      checks++;
      if (ow !== ew || od !== ed) begin
        errors++; $display("FAIL basic_addr got w=%h d=%h required w=%h d=%h", ow, od, ew, ed);
      end
    end
    while (exp_clr.size() > 0 && obs_clr.size() > 0) begin
      ec = exp_clr.pop_front(); oc = obs_clr.pop_front();
      checks++;
      if (oc !== ec) begin
        errors++; $display("FAIL basic_clr got %b required %b", oc, ec);
      end
    end
  endtask

  task automatic test_wrap();
    logic [9:0] ew, ed, ow, od;
    out_ready = 1'b1;
    begin_job(10'h3FE, 10'h3FF, 4);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 10) begin
        checks++;
        if (done !== 1'b1) begin
          errors++; $display("FAIL wrap_done cycle 10 got %b required 1", done);
        end
      end
      @(posedge clk); #1; start = 1'b0;
    end
    checks++;
    if (obs_w.size() != exp_w.size()) begin
      errors++; $display("FAIL wrap_count reads %0d required %0d", obs_w.size(), exp_w.size());
    end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      ew = exp_w.pop_front(); ed = exp_d.pop_front(); ow = obs_w.pop_front(); od = obs_d.pop_front();
      checks++;
      if (ow !== ew || od !== ed) begin
        errors++; $display("FAIL wrap_addr got w=%h d=%h required w=%h d=%h", ow, od, ew, ed);
      end
    end
  endtask

  task automatic test_backpressure();
    logic e_ov, e_done;
    out_ready = 1'b0;
    begin_job(10'h020, 10'h040, 2);
    // out_valid rises in cycle 7; out_ready stays low for cycles 7..11.
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      e_ov = (c >= 7 && c <= 12); e_done = (c == 13);
      checks++;
      if (out_valid !== e_ov || done !== e_done) begin
        errors++;
        $display("FAIL backpressure cycle %0d got out_valid=%b done=%b required %b %b",
                 c, out_valid, done, e_ov, e_done);
      end
      @(posedge clk); #1; start = 1'b0;
      if (c == 11) out_ready = 1'b1;
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL backpressure_done_count got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_zero();
    logic e_done;
    out_ready = 1'b1;
    begin_job(10'h055, 10'h066, 0);
    // start is kept high into the FIN cycle, where it must be ignored.
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      e_done = (c == 1);
      checks++;
      if (done !== e_done || busy !== e_done || w_rd_en !== 1'b0 || acc_en !== 1'b0 ||
          out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_tiles cycle %0d got done=%b busy=%b rd=%b acc=%b ov=%b required done=busy=%b rest 0",
                 c, done, busy, w_rd_en, acc_en, out_valid, e_done);
      end
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
    end
    checks++;
    if (done_cnt != 1 || obs_w.size() != 0 || obs_clr.size() != 0) begin
      errors++;
      $display("FAIL zero_totals got done=%0d reads=%0d acc=%0d required 1 0 0",
               done_cnt, obs_w.size(), obs_clr.size());
    end
  endtask

  task automatic test_ignore_start();
    logic [9:0] ew, ed, ow, od;
    out_ready = 1'b1;
    begin_job(10'h100, 10'h080, 4);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (c >= 1 && c <= 10) || done !== (c == 10)) begin
        errors++;
        $display("FAIL ignore_timing cycle %0d got busy=%b done=%b", c, busy, done);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 1) begin
        start = 1'b1; num_tiles = 10'd7; w_base = 10'h2AA; d_base = 10'h155;
      end
    end
    checks++;
    if (obs_w.size() != exp_w.size() || done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_count reads %0d required %0d, done %0d required 1",
               obs_w.size(), exp_w.size(), done_cnt);
    end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      ew = exp_w.pop_front(); ed = exp_d.pop_front(); ow = obs_w.pop_front(); od = obs_d.pop_front();
      checks++;
      if (ow !== ew || od !== ed) begin
        errors++; $display("FAIL ignore_addr got w=%h d=%h required w=%h d=%h", ow, od, ew, ed);
      end
    end
  endtask

  task automatic test_abort();
    logic oc;
    out_ready = 1'b1;
    begin_job(10'h000, 10'h000, 8);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; start = 1'b0;
    end
    // Now in cycle 3: pull reset mid-issue.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, w_rd_en, d_rd_en, acc_en, acc_clr, out_valid, done} !== 7'd0 ||
        w_rd_addr !== 10'd0 || d_rd_addr !== 10'd0) begin
      errors++;
      $display("FAIL abort_outputs got strobes=%b waddr=%h required all 0",
               {busy, w_rd_en, d_rd_en, acc_en, acc_clr, out_valid, done}, w_rd_addr);
    end
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 10; c++) @(posedge clk);
    checks++;
    if (done_cnt != 0) begin
      errors++; $display("FAIL abort_no_done got %0d done pulses required 0", done_cnt);
    end
    begin_job(10'h123, 10'h321, 1);
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1; start = 1'b0;
    end
    checks++;
    if (obs_clr.size() != 1 || obs_w.size() != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL abort_after_job got acc=%0d reads=%0d done=%0d required 1 1 1",
               obs_clr.size(), obs_w.size(), done_cnt);
    end
    if (obs_clr.size() > 0) begin
      oc = obs_clr.pop_front();
      checks++;
      if (oc !== 1'b1) begin
        errors++; $display("FAIL abort_after_clr got %b required 1", oc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_ignore_start();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
